dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
- Shares the single data-memory port between two requesters: port 0 (pipeline MEM stage) and port 1 (debug/DMA bridge).
- Each port has a valid/ready request channel and a valid/ready response channel; one transaction is outstanding at a time.
- Sits directly in front of DM, drives its address, write data and 4-bit operation, and captures its combinational read data.
- Rejects misaligned or out-of-range accesses: the DM write is suppressed and an error response is returned.

Parameters:
- DM_WORDS, 4096, number of 32-bit words in DM; addresses at or above DM_WORDS*4 are out of range.
- MAX_WAIT, 8, cycles port 1 may be refused while requesting before it wins priority.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- p0_req_valid, p1_req_valid  in  1 each  request present.
- p0_req_ready, p1_req_ready  out  1 each  request accepted this cycle.
- p0_addr, p1_addr  in  32 each  byte address.
- p0_wdata, p1_wdata  in  32 each  store data, right-aligned.
- p0_op, p1_op  in  4 each  DM operation: [3:1] width code (DMOP_*), [0] write enable.
- p0_rsp_valid, p1_rsp_valid  out  1 each  response pending.
- p0_rsp_ready, p1_rsp_ready  in  1 each  response consumed.
- rsp_rdata  out  32  load result, shared by both ports.
- rsp_err  out  1  access was misaligned or out of range.
- dm_addr  out  32  to DM.
- dm_wdata  out  32  to DM.
- dm_op  out  4  to DM.
- dm_rdata  in  32  from DM (combinational read).

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE, all ready/rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - rr_last=1, so port 0 is favoured first.
  - wait_cnt=0, dm_op=0 (no write).
- State IDLE:
  - Winner selection:
    - If exactly one port is valid, it wins.
    - If both are valid: port 1 wins when wait_cnt==MAX_WAIT; otherwise the port != rr_last wins (round-robin).
  - Only the winner's req_ready is high, combinationally.
  - dm_addr, dm_wdata and dm_op are driven combinationally from the winner.
  - dm_op[0] is forced to 0 if the access is in error, so DM performs no write.
  - With no valid request, dm_op=0.
- Handshake edge (valid&&ready):
  - Capture rsp_rdata=dm_rdata (0 on error or on a write), rsp_err, and owner=winner.
  - Set rr_last=winner and go to BUSY.
  - The DM write commits on the same edge, so request-to-response latency is 1 cycle.
- Error conditions:
  - WORD with addr[1:0]!=0.
  - HALF or HALFU with addr[0]=1.
  - addr >= DM_WORDS*4.
  - Width code not in the DMOP set.
- State BUSY:
  - The owner's rsp_valid=1; both req_ready=0; dm_op=0.
  - On the owner's rsp_ready, return to IDLE. Earliest next grant is the following cycle, so a port can complete at most one transaction every 2 cycles.
  - rsp_rdata and rsp_err are held stable while rsp_valid=1.
- wait_cnt:
  - Increments, saturating at MAX_WAIT, on every cycle where p1_req_valid=1 and p1 is not accepted (IDLE or BUSY).
  - Clears when p1 is accepted or when p1_req_valid=0.
- Requesters must hold addr, wdata and op stable while valid=1 and ready=0. The arbiter does not check this.
- Reset asserted mid-BUSY drops the response with no retry. A write already committed to DM remains committed.
- Simultaneous reset and handshake: reset wins and nothing is captured. DM's own synchronous clear is independent.

Decomposition:
- The shared macros/package holds:
  - the DMOP_WORD/BYTE/HALF/BYTEU/HALFU width codes;
  - the state encoding (IDLE=0, BUSY=1);
  - the op-field bit positions ([0] write enable, [3:1] width).
- One sub-module, dm_access_check: purely combinational, takes (addr, op) and outputs err. It is reusable by the DM bus bridge later.

Test Plan:
- p0 store {DMOP_WORD,1} addr 0x10 data 0xDEADBEEF, then a load from the same address:
  - ready on cycle 0, rsp_valid on cycle 1, rsp_err=0;
  - the load returns 0xDEADBEEF.
- Both ports valid continuously, both rsp_ready=1:
  - grants alternate p0,p1,p0,p1, one every 2 cycles;
  - the first grant goes to p0.
- p0 rsp_ready held low for 5 cycles:
  - p0_rsp_valid and rsp_rdata stay stable;
  - p1 sees no ready during this time;
  - p1 is granted 1 cycle after p0_rsp_ready rises.
- Misaligned HALF store at addr 0x13, and WORD store at DM_WORDS*4:
  - rsp_err=1, rsp_rdata=0;
  - a follow-up load shows memory unchanged.
- p0 priority forced every cycle (test hook) with p1 valid:
  - p1 is granted no later than its wait counter reaching MAX_WAIT=8;
  - wait_cnt clears on grant.
- reset pulled low while in BUSY:
  - all outputs go to their reset values immediately (asynchronously);
  - after release, the next request is granted normally.

Source files
------------

// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: DM operation encoding,
// FSM state encoding and small field-extraction helpers.
package dm_arbiter_pkg;

  localparam int OP_WE_BIT    = 0;
  localparam int OP_WIDTH_LSB = 1;
  localparam int OP_WIDTH_MSB = 3;

  // Width codes carried in op[3:1]; codes 3, 6 and 7 are undefined.
  localparam logic [2:0] DMOP_BYTE  = 3'd0;
  localparam logic [2:0] DMOP_HALF  = 3'd1;
  localparam logic [2:0] DMOP_WORD  = 3'd2;
  localparam logic [2:0] DMOP_BYTEU = 3'd4;
  localparam logic [2:0] DMOP_HALFU = 3'd5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  function automatic logic [2:0] op_width(input logic [3:0] op);
    return op[OP_WIDTH_MSB:OP_WIDTH_LSB];
  endfunction

  function automatic logic op_we(input logic [3:0] op);
    return op[OP_WE_BIT];
  endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// Requester channels and DM port of the arbiter, bundled as one interface.
interface dm_arbiter_if;

  // Request and response channels both transfer on a cycle where valid and
  // ready are high together; valid never waits on ready, payload is held
  // stable while valid is high and ready is low.
  logic        p0_req_valid;
  logic        p0_req_ready;
  logic [31:0] p0_addr;
  logic [31:0] p0_wdata;
  logic [3:0]  p0_op;
  logic        p0_rsp_valid;
  logic        p0_rsp_ready;

  logic        p1_req_valid;
  logic        p1_req_ready;
  logic [31:0] p1_addr;
  logic [31:0] p1_wdata;
  logic [3:0]  p1_op;
  logic        p1_rsp_valid;
  logic        p1_rsp_ready;

  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_op;
  logic [31:0] dm_rdata;

  modport slave (
    input  p0_req_valid, p0_addr, p0_wdata, p0_op, p0_rsp_ready,
    input  p1_req_valid, p1_addr, p1_wdata, p1_op, p1_rsp_ready,
    input  dm_rdata,
    output p0_req_ready, p0_rsp_valid, p1_req_ready, p1_rsp_valid,
    output rsp_rdata, rsp_err, dm_addr, dm_wdata, dm_op
  );

  modport master (
    output p0_req_valid, p0_addr, p0_wdata, p0_op, p0_rsp_ready,
    output p1_req_valid, p1_addr, p1_wdata, p1_op, p1_rsp_ready,
    output dm_rdata,
    input  p0_req_ready, p0_rsp_valid, p1_req_ready, p1_rsp_valid,
    input  rsp_rdata, rsp_err, dm_addr, dm_wdata, dm_op
  );

endinterface

// File: rtl/dm_access_check.sv
// Combinational legality check for a DM access: alignment for the width,
// a defined width code, and the address inside the memory.
module dm_access_check
  import dm_arbiter_pkg::*;
#(
  parameter int DM_WORDS = 4096
) (
  input  logic [31:0] i_addr,
  input  logic [3:0]  i_op,
  output logic        o_err
);

  localparam logic [31:0] ADDR_LIMIT = 32'(DM_WORDS * 4);

  logic w_misaligned;
  logic w_out_of_range;
  logic w_unused_we;

  // Legality does not depend on direction.
  assign w_unused_we = op_we(i_op);

  always_comb begin
    w_misaligned = 1'b0;
    case (op_width(i_op))
      DMOP_WORD:              w_misaligned = (i_addr[1:0] != 2'b00);
      DMOP_HALF, DMOP_HALFU:  w_misaligned = i_addr[0];
      DMOP_BYTE, DMOP_BYTEU:  w_misaligned = 1'b0;
      default:                w_misaligned = 1'b1;
    endcase
  end

  assign w_out_of_range = (i_addr >= ADDR_LIMIT);
  assign o_err          = w_misaligned | w_out_of_range;

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of the data memory: round-robin with a starvation
// bound for port 1, one outstanding transaction, 1-cycle response latency.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter  int DM_WORDS = 4096,
  parameter  int MAX_WAIT = 8,
  localparam int WAIT_W   = $clog2(MAX_WAIT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_force_p0,
  dm_arbiter_if.slave       bus,
  output state_t            o_dbg_state,
  output logic              o_dbg_owner,
  output logic [WAIT_W-1:0] o_dbg_wait_cnt
);

  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  state_t            r_state;
  state_t            w_next_state;
  logic              r_owner;
  logic              r_rr_last;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_err;

  logic        w_idle;
  logic        w_winner;
  logic        w_grant;
  logic        w_p1_accept;
  logic        w_err;
  logic        w_owner_rsp_ready;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [3:0]  w_op;

  // Grants are gated by reset so nothing is offered or written while held.
  assign w_idle = (r_state == ST_IDLE) && reset;

  always_comb begin
    w_winner = bus.p1_req_valid;
    if (bus.p0_req_valid && bus.p1_req_valid) begin
      if (r_wait_cnt == WAIT_MAX) w_winner = 1'b1;
      else if (i_force_p0)        w_winner = 1'b0;
      else                        w_winner = ~r_rr_last;
    end
  end

  assign w_grant           = w_idle && (bus.p0_req_valid || bus.p1_req_valid);
  assign w_p1_accept       = w_grant && w_winner;
  assign w_addr            = w_winner ? bus.p1_addr  : bus.p0_addr;
  assign w_wdata           = w_winner ? bus.p1_wdata : bus.p0_wdata;
  assign w_op              = w_winner ? bus.p1_op    : bus.p0_op;
  assign w_owner_rsp_ready = r_owner ? bus.p1_rsp_ready : bus.p0_rsp_ready;

  dm_access_check #(.DM_WORDS(DM_WORDS)) u_check (
    .i_addr (w_addr),
    .i_op   (w_op),
    .o_err  (w_err)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (r_state == ST_IDLE) begin
      if (w_grant) w_next_state = ST_BUSY;
    end else begin
      if (w_owner_rsp_ready) w_next_state = ST_IDLE;
    end
  end

  always_comb begin
    bus.p0_req_ready = w_grant && !w_winner;
    bus.p1_req_ready = w_grant && w_winner;
    bus.p0_rsp_valid = (r_state == ST_BUSY) && !r_owner;
    bus.p1_rsp_valid = (r_state == ST_BUSY) && r_owner;
    bus.dm_addr      = w_addr;
    bus.dm_wdata     = w_wdata;
    bus.dm_op        = 4'd0;
    if (w_grant) bus.dm_op = {op_width(w_op), op_we(w_op) & ~w_err};
  end

  // The DM write commits on the grant edge, so the response is captured there too.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner     <= 1'b0;
      r_rr_last   <= 1'b1;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else if (w_grant) begin
      r_owner     <= w_winner;
      r_rr_last   <= w_winner;
      r_rsp_err   <= w_err;
      r_rsp_rdata <= (w_err || op_we(w_op)) ? '0 : bus.dm_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait_cnt <= '0;
    end else if (bus.p1_req_valid && !w_p1_accept) begin
      if (r_wait_cnt != WAIT_MAX) r_wait_cnt <= r_wait_cnt + 1'b1;
    end else begin
      r_wait_cnt <= '0;
    end
  end

  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.rsp_err     = r_rsp_err;
  assign o_dbg_state     = r_state;
  assign o_dbg_owner     = r_owner;
  assign o_dbg_wait_cnt  = r_wait_cnt;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: per-transaction vector table plus
// hand-written multi-cycle sequences, against a small behavioural DM.
module tb_dm_arbiter;
  import dm_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       force_p0 = 1'b0;
  state_t     dbg_state;
  logic       dbg_owner;
  logic [3:0] dbg_wait_cnt;

  int checks = 0;
  int errors = 0;

  dm_arbiter_if bus ();

  dm_arbiter dut (
    .clk            (clk),
    .reset          (rst_n),
    .i_force_p0     (force_p0),
    .bus            (bus),
    .o_dbg_state    (dbg_state),
    .o_dbg_owner    (dbg_owner),
    .o_dbg_wait_cnt (dbg_wait_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural DM: combinational word read, byte-lane writes on the clock.
  logic [31:0] mem [0:4095];
  assign bus.dm_rdata = mem[bus.dm_addr[13:2]];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] a,
                                        input logic [2:0] w, input logic [31:0] d);
    logic [31:0] r;
    r = old;
    case (w)
      3'd2: r = d;
      3'd1: if (a[1]) r[31:16] = d[15:0]; else r[15:0] = d[15:0];
      3'd0: case (a)
              2'd0: r[7:0]   = d[7:0];
              2'd1: r[15:8]  = d[7:0];
              2'd2: r[23:16] = d[7:0];
              default: r[31:24] = d[7:0];
            endcase
      default: r = old;
    endcase
    return r;
  endfunction

  always @(posedge clk)
    if (bus.dm_op[0])
      mem[bus.dm_addr[13:2]] <= merge(mem[bus.dm_addr[13:2]], bus.dm_addr[1:0],
                                      bus.dm_op[3:1], bus.dm_wdata);

  typedef struct {
    logic        p0v; logic [31:0] p0a; logic [31:0] p0d; logic [3:0] p0o;
    logic        p1v; logic [31:0] p1a; logic [31:0] p1d; logic [3:0] p1o;
    logic        win; logic [3:0] dm_op; logic err; logic [31:0] rdata;
  } vec_t;

  vec_t        vq[$];
  logic [31:0] exp_q[$];

  function automatic vec_t mk(logic p0v, logic [31:0] p0a, logic [31:0] p0d, logic [3:0] p0o,
                              logic p1v, logic [31:0] p1a, logic [31:0] p1d, logic [3:0] p1o,
                              logic win, logic [3:0] dm_op, logic err, logic [31:0] rdata);
    vec_t v;
    v.p0v = p0v; v.p0a = p0a; v.p0d = p0d; v.p0o = p0o;
    v.p1v = p1v; v.p1a = p1a; v.p1d = p1d; v.p1o = p1o;
    v.win = win; v.dm_op = dm_op; v.err = err; v.rdata = rdata;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.p0_req_valid = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0; bus.p0_op = '0;
    bus.p1_req_valid = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0; bus.p1_op = '0;
    bus.p0_rsp_ready = 1'b0; bus.p1_rsp_ready = 1'b0;
    force_p0 = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [1:0] oh;
    oh = v.win ? 2'b10 : 2'b01;
    @(negedge clk);
    bus.p0_req_valid = v.p0v; bus.p0_addr = v.p0a; bus.p0_wdata = v.p0d; bus.p0_op = v.p0o;
    bus.p1_req_valid = v.p1v; bus.p1_addr = v.p1a; bus.p1_wdata = v.p1d; bus.p1_op = v.p1o;
    #1;
    check($sformatf("v%0d req_ready", idx), 32'({bus.p1_req_ready, bus.p0_req_ready}), 32'(oh));
    check($sformatf("v%0d dm_op", idx), 32'(bus.dm_op), 32'(v.dm_op));
    check($sformatf("v%0d dm_addr", idx), bus.dm_addr, v.win ? v.p1a : v.p0a);
    check($sformatf("v%0d dm_wdata", idx), bus.dm_wdata, v.win ? v.p1d : v.p0d);
    @(negedge clk);
    bus.p0_req_valid = 1'b0; bus.p1_req_valid = 1'b0;
    #1;
    check($sformatf("v%0d rsp_valid", idx), 32'({bus.p1_rsp_valid, bus.p0_rsp_valid}), 32'(oh));
    check($sformatf("v%0d rsp_err", idx), 32'(bus.rsp_err), 32'(v.err));
    check($sformatf("v%0d rsp_rdata", idx), bus.rsp_rdata, v.rdata);
    if (v.win) bus.p1_rsp_ready = 1'b1; else bus.p0_rsp_ready = 1'b1;
    @(negedge clk);
    bus.p0_rsp_ready = 1'b0; bus.p1_rsp_ready = 1'b0;
    #1;
    check($sformatf("v%0d back_idle", idx), 32'(dbg_state), 32'(ST_IDLE));
  endtask

  initial begin
    int got;
    idle_inputs();

    // Reset values while reset is held.
    repeat (2) @(negedge clk);
    #1;
    check("rst rsp_valid", 32'({bus.p1_rsp_valid, bus.p0_rsp_valid}), 32'h0);
    check("rst rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst rsp_err", 32'(bus.rsp_err), 32'h0);
    check("rst dm_op", 32'(bus.dm_op), 32'h0);
    check("rst wait_cnt", 32'(dbg_wait_cnt), 32'h0);
    check("rst state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    // Ops: WORD st 5 / ld 4, HALF st 3, HALFU ld A, BYTE st 1, undefined width F.
    vq.push_back(mk(1, 32'h10,   32'hDEADBEEF, 4'h5, 0, 0,       0,            4'h0, 0, 4'h5, 0, 32'h0));
    vq.push_back(mk(1, 32'h10,   0,            4'h4, 0, 0,       0,            4'h0, 0, 4'h4, 0, 32'hDEADBEEF));
    vq.push_back(mk(0, 0,        0,            4'h0, 1, 32'h20,  32'h11223344, 4'h5, 1, 4'h5, 0, 32'h0));
    vq.push_back(mk(1, 32'h0,    32'h0BADF00D, 4'h5, 0, 0,       0,            4'h0, 0, 4'h5, 0, 32'h0));
    vq.push_back(mk(1, 32'h20,   0,            4'h4, 1, 32'h10,  0,            4'h4, 1, 4'h4, 0, 32'hDEADBEEF));
    vq.push_back(mk(1, 32'h20,   0,            4'h4, 1, 32'h10,  0,            4'h4, 0, 4'h4, 0, 32'h11223344));
    vq.push_back(mk(0, 0,        0,            4'h0, 1, 32'h13,  32'h0000FFFF, 4'h3, 1, 4'h2, 1, 32'h0));
    vq.push_back(mk(1, 32'h4000, 32'hCAFEF00D, 4'h5, 0, 0,       0,            4'h0, 0, 4'h4, 1, 32'h0));
    vq.push_back(mk(1, 32'h10,   0,            4'h4, 0, 0,       0,            4'h0, 0, 4'h4, 0, 32'hDEADBEEF));
    vq.push_back(mk(1, 32'h0,    0,            4'h4, 0, 0,       0,            4'h0, 0, 4'h4, 0, 32'h0BADF00D));
    vq.push_back(mk(0, 0,        0,            4'h0, 1, 32'h3FFC, 32'h5A5A5A5A, 4'h5, 1, 4'h5, 0, 32'h0));
    vq.push_back(mk(0, 0,        0,            4'h0, 1, 32'h3FFC, 0,            4'h4, 1, 4'h4, 0, 32'h5A5A5A5A));
    vq.push_back(mk(1, 32'h12,   0,            4'hA, 0, 0,       0,            4'h0, 0, 4'hA, 0, 32'hDEADBEEF));
    vq.push_back(mk(1, 32'h20,   32'h1,        4'hF, 0, 0,       0,            4'h0, 0, 4'hE, 1, 32'h0));
    vq.push_back(mk(1, 32'h22,   0,            4'h4, 0, 0,       0,            4'h0, 0, 4'h4, 1, 32'h0));
    vq.push_back(mk(1, 32'h21,   32'h000000AB, 4'h1, 0, 0,       0,            4'h0, 0, 4'h1, 0, 32'h0));
    vq.push_back(mk(1, 32'h20,   0,            4'h4, 0, 0,       0,            4'h0, 0, 4'h4, 0, 32'h1122AB44));
    vq.push_back(mk(1, 32'h12,   32'h00001234, 4'h3, 0, 0,       0,            4'h0, 0, 4'h3, 0, 32'h0));
    vq.push_back(mk(1, 32'h10,   0,            4'h4, 0, 0,       0,            4'h0, 0, 4'h4, 0, 32'h1234BEEF));
    for (int i = 0; i < vq.size(); i++) run_vec(vq[i], i);

    // Continuous contention: grants alternate p0,p1 every 2 cycles, p0 first.
    reset_dut();
    exp_q = {32'h1, 32'h0, 32'h2, 32'h0, 32'h1, 32'h0, 32'h2, 32'h0};
    bus.p0_req_valid = 1'b1; bus.p0_addr = 32'h10; bus.p0_op = 4'h4;
    bus.p1_req_valid = 1'b1; bus.p1_addr = 32'h20; bus.p1_op = 4'h4;
    bus.p0_rsp_ready = 1'b1; bus.p1_rsp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      check($sformatf("rr c%0d grant", c), 32'({bus.p1_req_ready, bus.p0_req_ready}), exp_q.pop_front());
      @(negedge clk);
    end

    // p0 response stalled 5 cycles; p1 waits, then wins the cycle after release.
    reset_dut();
    bus.p0_req_valid = 1'b1; bus.p0_addr = 32'h10; bus.p0_op = 4'h4;
    bus.p1_req_valid = 1'b1; bus.p1_addr = 32'h20; bus.p1_op = 4'h4;
    #1;
    check("stall p0 grant", 32'({bus.p1_req_ready, bus.p0_req_ready}), 32'h1);
    @(negedge clk);
    bus.p0_req_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      #1;
      check($sformatf("stall c%0d p0_rsp_valid", c), 32'(bus.p0_rsp_valid), 32'h1);
      check($sformatf("stall c%0d rsp_rdata", c), bus.rsp_rdata, 32'h1234BEEF);
      check($sformatf("stall c%0d p1_req_ready", c), 32'(bus.p1_req_ready), 32'h0);
      @(negedge clk);
    end
    bus.p0_rsp_ready = 1'b1;
    #1;
    check("stall release p1_req_ready", 32'(bus.p1_req_ready), 32'h0);
    @(negedge clk);
    bus.p0_rsp_ready = 1'b0;
    #1;
    check("stall p1 grant", 32'(bus.p1_req_ready), 32'h1);
    check("stall p0_rsp_valid low", 32'(bus.p0_rsp_valid), 32'h0);
    check("stall wait_cnt", 32'(dbg_wait_cnt), 32'd7);
    @(negedge clk);
    bus.p1_req_valid = 1'b0;
    #1;
    check("stall p1 rsp_valid", 32'(bus.p1_rsp_valid), 32'h1);
    check("stall p1 rdata", bus.rsp_rdata, 32'h1122AB44);
    check("stall wait cleared", 32'(dbg_wait_cnt), 32'h0);
    bus.p1_rsp_ready = 1'b1;
    @(negedge clk);
    bus.p1_rsp_ready = 1'b0;

    // p0 forced to win ties: p1 still wins once its wait count hits 8.
    reset_dut();
    force_p0 = 1'b1;
    bus.p0_req_valid = 1'b1; bus.p0_addr = 32'h10; bus.p0_op = 4'h4;
    bus.p1_req_valid = 1'b1; bus.p1_addr = 32'h20; bus.p1_op = 4'h4;
    bus.p0_rsp_ready = 1'b1; bus.p1_rsp_ready = 1'b1;
    exp_q = {32'h1, 32'h0, 32'h1, 32'h0, 32'h1, 32'h0, 32'h1, 32'h0, 32'h2};
    got = -1;
    for (int c = 0; c < 30 && got < 0; c++) begin
      #1;
      if (exp_q.size() > 0)
        check($sformatf("force c%0d grant", c), 32'({bus.p1_req_ready, bus.p0_req_ready}),
              exp_q.pop_front());
      if (bus.p1_req_ready) begin
        got = c;
        check("force wait at grant", 32'(dbg_wait_cnt), 32'd8);
      end
      @(negedge clk);
    end
    check("force p1 grant cycle", 32'(got), 32'd8);
    #1;
    check("force wait cleared", 32'(dbg_wait_cnt), 32'h0);
    check("force p1 rsp_valid", 32'(bus.p1_rsp_valid), 32'h1);
    idle_inputs();
    @(negedge clk);

    // Asynchronous reset during BUSY; the committed write survives.
    reset_dut();
    bus.p0_req_valid = 1'b1; bus.p0_addr = 32'h30; bus.p0_wdata = 32'h77; bus.p0_op = 4'h5;
    #1;
    check("rbusy p0 grant", 32'(bus.p0_req_ready), 32'h1);
    @(negedge clk);
    bus.p0_req_valid = 1'b0;
    bus.p1_req_valid = 1'b1; bus.p1_addr = 32'h30; bus.p1_op = 4'h4;
    #1;
    check("rbusy p0_rsp_valid", 32'(bus.p0_rsp_valid), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rbusy async rsp_valid", 32'({bus.p1_rsp_valid, bus.p0_rsp_valid}), 32'h0);
    check("rbusy async state", 32'(dbg_state), 32'(ST_IDLE));
    check("rbusy async req_ready", 32'({bus.p1_req_ready, bus.p0_req_ready}), 32'h0);
    check("rbusy async dm_op", 32'(bus.dm_op), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rbusy p1 grant", 32'(bus.p1_req_ready), 32'h1);
    check("rbusy p1 dm_addr", bus.dm_addr, 32'h30);
    @(negedge clk);
    bus.p1_req_valid = 1'b0;
    #1;
    check("rbusy p1 rsp_valid", 32'(bus.p1_rsp_valid), 32'h1);
    check("rbusy committed write", bus.rsp_rdata, 32'h77);
    bus.p1_rsp_ready = 1'b1;
    @(negedge clk);
    bus.p1_rsp_ready = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
